// File: rtl/mux_4to1_if.sv
// ============================================================================
// Module      : mux_4to1_if
// Description : Bus bundle for the registered 4-to-1 mux. y_par exists only
//               when MUX_4TO1_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux_4to1_if #(
   parameter int WIDTH = 1
);
   logic             en;
   logic [1:0]       sel;
   logic [WIDTH-1:0] i0;
   logic [WIDTH-1:0] i1;
   logic [WIDTH-1:0] i2;
   logic [WIDTH-1:0] i3;
   logic [WIDTH-1:0] y;
   logic             y_valid;
`ifdef MUX_4TO1_PARITY_EN
   logic             y_par;
`endif

   modport master (
      output en, sel, i0, i1, i2, i3,
      input  y, y_valid
`ifdef MUX_4TO1_PARITY_EN
      , input y_par
`endif
   );

   modport slave (
      input  en, sel, i0, i1, i2, i3,
      output y, y_valid
`ifdef MUX_4TO1_PARITY_EN
      , output y_par
`endif
   );
endinterface

`default_nettype wire

// File: rtl/mux_4to1.sv
// ============================================================================
// Module      : mux_4to1
// Description : Registered 4-to-1 multiplexer with capture enable and sticky
//               valid flag. Define MUX_4TO1_PARITY_EN to add registered y_par.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_4to1 #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   mux_4to1_if.slave  bus
);

   logic [WIDTH-1:0] w_d_next;
   logic [WIDTH-1:0] r_y;
   logic             r_valid;

   // Non-0..3 selects (X/Z in simulation) fall through to i0.
   always_comb begin
      w_d_next = bus.i0;
      case (bus.sel)
         2'd1:    w_d_next = bus.i1;
         2'd2:    w_d_next = bus.i2;
         2'd3:    w_d_next = bus.i3;
         default: w_d_next = bus.i0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y     <= RESET_VAL;
         r_valid <= 1'b0;
      end else if (bus.en) begin
         r_y     <= w_d_next;
         r_valid <= 1'b1;
      end
   end

   assign bus.y       = r_y;
   assign bus.y_valid = r_valid;

`ifdef MUX_4TO1_PARITY_EN
   logic r_par;

   // Parity is registered from the same next value so it tracks y exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par <= ^RESET_VAL;
      end else if (bus.en) begin
         r_par <= ^w_d_next;
      end
   end

   assign bus.y_par = r_par;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: directed cases on WIDTH=1 and WIDTH=8
// instances, then randomized traffic against an array-indexed reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_mux_4to1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mux_4to1_if #(.WIDTH(1)) b1 ();
   mux_4to1_if #(.WIDTH(8)) b8 ();

   mux_4to1 #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   mux_4to1 #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

   always #5 clk = ~clk;

   logic       a1 [4];
   logic [7:0] a8 [4];
   logic       exp1, v1, v8;
   logic [7:0] exp8;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      b1.i0 = a1[0]; b1.i1 = a1[1]; b1.i2 = a1[2]; b1.i3 = a1[3];
      b8.i0 = a8[0]; b8.i1 = a8[1]; b8.i2 = a8[2]; b8.i3 = a8[3];
   endtask

   task automatic model_reset();
      exp1 = 1'b0; v1 = 1'b0;
      exp8 = 8'h00; v8 = 1'b0;
   endtask

   // Reference: an enabled edge loads the input chosen by sel; otherwise hold.
   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         if (b1.en) begin exp1 = a1[b1.sel]; v1 = 1'b1; end
         if (b8.en) begin exp8 = a8[b8.sel]; v8 = 1'b1; end
      end
      #1;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_y1"}, 64'(b1.y), 64'(exp1));
      check({tag, "_v1"}, 64'(b1.y_valid), 64'(v1));
      check({tag, "_y8"}, 64'(b8.y), 64'(exp8));
      check({tag, "_v8"}, 64'(b8.y_valid), 64'(v8));
`ifdef MUX_4TO1_PARITY_EN
      check({tag, "_par8"}, 64'(b8.y_par), 64'(^exp8));
      check({tag, "_par1"}, 64'(b1.y_par), 64'(exp1));
`endif
   endtask

   initial begin
      b1.en = 1'b0; b1.sel = 2'd0;
      b8.en = 1'b0; b8.sel = 2'd0;
      a1 = '{1'b1, 1'b0, 1'b1, 1'b0};
      a8 = '{8'h05, 8'h07, 8'h09, 8'h0B};
      drive();
      model_reset();

      // Reset state, held across an edge
      #2 check_all("reset");
      tick();
      check_all("reset_edge");

      // Sweep sel 0..3 on WIDTH=1 with {i3,i2,i1,i0}=0101
      @(negedge clk);
      rst_n = 1'b1;
      b1.en = 1'b1;
      for (int s = 0; s < 4; s++) begin
         b1.sel = 2'(s);
         tick();
         check_all($sformatf("sweep1_s%0d", s));
         @(negedge clk);
      end

      // Bring y to 1 then reset asynchronously between edges
      b1.sel = 2'd0;
      tick();
      check_all("pre_rst");
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all("async_rst");
      tick();
      check_all("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      b1.sel = 2'd2;
      tick();
      check_all("post_rst");

      // Hold with en=0 over three edges, then release
      @(negedge clk);
      b1.en = 1'b0;
      b1.sel = 2'd1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_all($sformatf("hold_%0d", k));
      end
      @(negedge clk);
      b1.en = 1'b1;
      tick();
      check_all("hold_release");

      // WIDTH=8 descending sweep (also exercises parity 0B/09/07/05)
      @(negedge clk);
      b1.en = 1'b0;
      b8.en = 1'b1;
      for (int s = 3; s >= 0; s--) begin
         b8.sel = 2'(s);
         tick();
         check_all($sformatf("sweep8_s%0d", s));
         @(negedge clk);
      end

      // Randomized traffic; y must not move between edges
      for (int n = 0; n < 40; n++) begin
         for (int j = 0; j < 4; j++) begin
            a1[j] = 1'($urandom);
            a8[j] = 8'($urandom);
         end
         drive();
         b1.sel = 2'($urandom);
         b8.sel = 2'($urandom);
         b1.en  = 1'($urandom_range(0, 3) != 0);
         b8.en  = 1'($urandom_range(0, 3) != 0);
         #1 check_all($sformatf("rnd_stable_%0d", n));
         tick();
         check_all($sformatf("rnd_%0d", n));
         @(negedge clk);
      end

      // Reset mid-traffic discards pending capture
      b8.en = 1'b1;
      #1 rst_n = 1'b0;
      model_reset();
      #1 check_all("final_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      errors++;
      $display("FAIL timeout: observed=running expected=finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
